// File: rtl/frog_pkg.sv
// frog_pkg: shared types and constants for the frog collision detector
package frog_pkg;
  localparam int CNT_W = 11;
  localparam int DEF_NUM_LOGS = 8;
  localparam int DEF_NUM_CARS = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, EVAL, REPORT} state_t;
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/sat_pixel_counter.sv
// sat_pixel_counter: per-frame pixel counter that sticks at all-ones
module sat_pixel_counter
  import frog_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // clear wins over increment; increment stops at all-ones
  always_comb cnt_d = clear ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk) cnt_q <= !resetN ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/frog_collision_detect.sv
// frog_collision_detect: per-frame frog overlap counting, log scan and event reporting
module frog_collision_detect
  import frog_pkg::*;
#(
  parameter int NUM_LOGS    = DEF_NUM_LOGS,
  parameter int NUM_CARS    = DEF_NUM_CARS,
  parameter int MIN_SUPPORT = 64,
  localparam int IW = NUM_LOGS > 1 ? $clog2(NUM_LOGS) : 1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                game_active,
  input  logic                frog_draw_req,
  input  logic [NUM_LOGS-1:0] logs_draw_req,
  input  logic [NUM_CARS-1:0] cars_draw_req,
  input  logic                river_draw_req,
  input  logic                goal_draw_req,
  output logic                hit_pulse,
  output logic                drown_pulse,
  output logic                goal_pulse,
  output logic                ride_valid,
  output logic [IW-1:0]       ride_log_idx
);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, max_idx_q, max_idx_d, ride_idx_q, ride_idx_d;
  logic [CNT_W-1:0] max_q, max_d, support_q, support_d, cur;
  logic ride_valid_q, ride_valid_d;
  logic count_en, clear, last, first, take, report, drown_c;
  logic [CNT_W-1:0] car_cnt, river_cnt, goal_cnt;
  logic [CNT_W-1:0] log_cnt [NUM_LOGS];

  assign count_en = state_q == ACCUM && !startOfFrame;
  assign clear    = (state_q == IDLE && startOfFrame) || state_q == REPORT;
  assign last     = state_q == EVAL && idx_q == IW'(NUM_LOGS - 1);
  assign first    = idx_q == '0;
  assign cur      = log_cnt[idx_q];
  assign take     = first || cur > max_q;

  sat_pixel_counter u_car (.clk(clk), .resetN(resetN), .clear(clear),
    .inc(count_en && frog_draw_req && |cars_draw_req), .cnt(car_cnt));
  sat_pixel_counter u_river (.clk(clk), .resetN(resetN), .clear(clear),
    .inc(count_en && frog_draw_req && river_draw_req && !(|logs_draw_req)), .cnt(river_cnt));
  sat_pixel_counter u_goal (.clk(clk), .resetN(resetN), .clear(clear),
    .inc(count_en && frog_draw_req && goal_draw_req), .cnt(goal_cnt));
  for (genvar i = 0; i < NUM_LOGS; i++) begin : g_log
    sat_pixel_counter u_log (.clk(clk), .resetN(resetN), .clear(clear),
      .inc(count_en && frog_draw_req && logs_draw_req[i]), .cnt(log_cnt[i]));
  end

  // frame sequencing and the one-log-per-cycle max/sum scan
  always_comb begin
    state_d      = state_q == IDLE  ? (startOfFrame ? ACCUM : IDLE)
                 : state_q == ACCUM ? (startOfFrame ? EVAL : ACCUM)
                 : state_q == EVAL  ? (last ? REPORT : EVAL)
                 : ACCUM;
    idx_d        = (state_q == EVAL && !last) ? idx_q + 1'b1 : '0;
    max_d        = state_q != EVAL ? max_q : take ? cur : max_q;
    max_idx_d    = state_q != EVAL ? max_idx_q : take ? idx_q : max_idx_q;
    support_d    = state_q != EVAL ? support_q : first ? cur : sat_add(support_q, cur);
    ride_valid_d = last ? max_d >= CNT_W'(MIN_SUPPORT) : ride_valid_q;
    ride_idx_d   = last ? (max_d >= CNT_W'(MIN_SUPPORT) ? max_idx_d : '0) : ride_idx_q;
  end

  // prioritised event decode, live only during the report cycle
  always_comb begin
    report      = state_q == REPORT && game_active;
    drown_c     = river_cnt != '0 && support_q < CNT_W'(MIN_SUPPORT);
    hit_pulse   = report && car_cnt != '0;
    drown_pulse = report && car_cnt == '0 && drown_c;
    goal_pulse  = report && car_cnt == '0 && !drown_c && goal_cnt != '0;
  end

  // state, scan and ride registers
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      max_q        <= '0;
      max_idx_q    <= '0;
      support_q    <= '0;
      ride_valid_q <= 1'b0;
      ride_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      max_q        <= max_d;
      max_idx_q    <= max_idx_d;
      support_q    <= support_d;
      ride_valid_q <= ride_valid_d;
      ride_idx_q   <= ride_idx_d;
    end
  end

  assign ride_valid   = ride_valid_q;
  assign ride_log_idx = ride_idx_q;
endmodule

// File: tb/tb_frog_collision_detect.sv
// tb_frog_collision_detect: directed frame vectors plus reset and saturation sequences
module tb_frog_collision_detect;
  logic clk = 0, resetN = 0, startOfFrame = 0, game_active = 1, frog = 0, river = 0, goal = 0;
  logic [7:0] logs = 0, cars = 0;
  logic hit_pulse, drown_pulse, goal_pulse, ride_valid;
  logic [2:0] ride_log_idx;
  int errors = 0, checks = 0;

  frog_collision_detect dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .game_active(game_active),
    .frog_draw_req(frog), .logs_draw_req(logs), .cars_draw_req(cars),
    .river_draw_req(river), .goal_draw_req(goal),
    .hit_pulse(hit_pulse), .drown_pulse(drown_pulse), .goal_pulse(goal_pulse),
    .ride_valid(ride_valid), .ride_log_idx(ride_log_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int car_i, car_n, la, la_n, lb, lb_n, river_n, goal_n;
    bit act, noise;
    bit [2:0] e_ev;
    bit e_rv;
    int e_idx;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int n, input logic [7:0] lg, input logic [7:0] cr, input logic rv, input logic gl);
    repeat (n) begin
      frog = 1; logs = lg; cars = cr; river = rv; goal = gl;
      tick();
    end
    frog = 0; logs = 0; cars = 0; river = 0; goal = 0;
  endtask

  task automatic watch(input bit noise, output bit [2:0] ev9, output int extra, output int rv9, output int idx9);
    bit [2:0] ev;
    ev9 = 0; extra = 0; rv9 = 0; idx9 = 0;
    startOfFrame = 1;
    tick();
    startOfFrame = 0;
    for (int k = 1; k <= 12; k++) begin
      if (noise && k <= 8) begin
        frog = 1; cars = 8'hff; logs = 8'h0f; river = 1; goal = 1; startOfFrame = (k == 4);
      end else begin
        frog = 0; cars = 0; logs = 0; river = 0; goal = 0; startOfFrame = 0;
      end
      #4;
      ev = {hit_pulse, drown_pulse, goal_pulse};
      if (k == 9) begin
        ev9 = ev; rv9 = int'(ride_valid); idx9 = int'(ride_log_idx);
      end else if (ev != 0) extra++;
      tick();
    end
  endtask

  task automatic play(input vec_t v);
    bit [2:0] ev;
    int extra, rv, ri;
    game_active = v.act;
    drive(v.car_n, 8'h00, 8'(1 << v.car_i), 1'b0, 1'b0);
    drive(v.la_n, 8'(1 << v.la), 8'h00, 1'b1, 1'b0);
    drive(v.lb_n, 8'(1 << v.lb), 8'h00, 1'b1, 1'b0);
    drive(v.river_n, 8'h00, 8'h00, 1'b1, 1'b0);
    drive(v.goal_n, 8'h00, 8'h00, 1'b0, 1'b1);
    watch(v.noise, ev, extra, rv, ri);
    check({v.nm, " events"}, int'(ev), int'(v.e_ev));
    check({v.nm, " stray"}, extra, 0);
    check({v.nm, " ride_valid"}, rv, int'(v.e_rv));
    check({v.nm, " ride_idx"}, ri, v.e_idx);
  endtask

  initial begin
    bit [2:0] ev;
    int extra, rv, ri, stray;
    vecs[0]  = '{"car5",      5, 10, 0, 0,   0, 0,   0,   0, 1, 0, 3'b100, 0, 0};
    vecs[1]  = '{"log3ride",  0, 0,  3, 200, 0, 0,   50,  0, 1, 0, 3'b000, 1, 3};
    vecs[2]  = '{"drown",     0, 0,  2, 40,  0, 0,   300, 0, 1, 0, 3'b010, 0, 0};
    vecs[3]  = '{"tie",       0, 0,  1, 100, 6, 100, 0,   0, 1, 0, 3'b000, 1, 1};
    vecs[4]  = '{"cargoal",   1, 5,  0, 0,   0, 0,   0,   7, 1, 0, 3'b100, 0, 0};
    vecs[5]  = '{"goal",      0, 0,  0, 0,   0, 0,   0,   20, 1, 0, 3'b001, 0, 0};
    vecs[6]  = '{"inactive",  2, 5,  4, 100, 0, 0,   0,   0, 0, 0, 3'b000, 1, 4};
    vecs[7]  = '{"emptynoise",0, 0,  0, 0,   0, 0,   0,   0, 1, 1, 3'b000, 0, 0};
    vecs[8]  = '{"minexact",  0, 0,  5, 64,  0, 0,   5,   0, 1, 0, 3'b000, 1, 5};
    vecs[9]  = '{"minless",   0, 0,  5, 63,  0, 0,   5,   0, 1, 0, 3'b010, 0, 0};
    vecs[10] = '{"splitsup",  0, 0,  0, 40,  7, 40,  10,  0, 1, 0, 3'b000, 0, 0};
    vecs[11] = '{"supgoal",   0, 0,  0, 70,  0, 0,   10,  5, 1, 0, 3'b001, 1, 0};
    vecs[12] = '{"drowngoal", 0, 0,  0, 0,   0, 0,   10,  10, 1, 0, 3'b010, 0, 0};

    tick(); tick();
    check("reset pulses", int'({hit_pulse, drown_pulse, goal_pulse}), 0);
    check("reset ride_valid", int'(ride_valid), 0);
    check("reset ride_idx", int'(ride_log_idx), 0);
    resetN = 1;
    startOfFrame = 1;
    tick();
    startOfFrame = 0;

    for (int i = 0; i < 13; i++) play(vecs[i]);

    game_active = 1;
    drive(3000, 8'h00, 8'h01, 1'b0, 1'b0);
    check("car_cnt saturate", int'(dut.car_cnt), 2047);
    watch(0, ev, extra, rv, ri);
    check("sat hit", int'(ev), 3'b100);
    check("sat stray", extra, 0);

    drive(10, 8'h00, 8'h20, 1'b0, 1'b0);
    startOfFrame = 1;
    tick();
    startOfFrame = 0;
    tick(); tick(); tick();
    resetN = 0;
    tick();
    resetN = 1;
    stray = 0;
    for (int k = 0; k < 14; k++) begin
      #4;
      if ({hit_pulse, drown_pulse, goal_pulse} != 0) stray++;
      tick();
    end
    check("reset midEVAL pulses", stray, 0);
    check("reset midEVAL ride_valid", int'(ride_valid), 0);

    drive(10, 8'h00, 8'h01, 1'b0, 1'b0);
    startOfFrame = 1;
    tick();
    startOfFrame = 0;
    watch(0, ev, extra, rv, ri);
    check("idle partial frame", int'(ev), 0);
    drive(10, 8'h00, 8'h20, 1'b0, 1'b0);
    watch(0, ev, extra, rv, ri);
    check("post-reset hit", int'(ev), 3'b100);
    check("post-reset stray", extra, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
